// File: rtl/project3b_top.sv
// project3b_top: board-level combination lock. Three correct 7-bit codes
// entered in order on SW (each confirmed with KEY[0]) open the lock; too many
// wrong entries latch an alarm that only KEY[1] reset clears.
module project3b_top #(
    parameter logic [6:0]  CODE0    = 7'h12,
    parameter logic [6:0]  CODE1    = 7'h34,
    parameter logic [6:0]  CODE2    = 7'h56,
    parameter int unsigned MAX_FAIL = 3
) (
    input  logic       CLOCK_50,
    input  logic [1:0] KEY,
    input  logic [6:0] SW,
    output logic [6:0] HEX3,
    output logic [6:0] HEX2,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0,
    output logic [6:0] LED
);

    // State encodings double as the hex digit shown on HEX1.
    typedef enum logic [3:0] {
        S_LOCKED = 4'h0,
        S_GOT1   = 4'h1,
        S_GOT2   = 4'h2,
        S_OPEN   = 4'h3,
        S_ALARM  = 4'hE
    } state_t;

    localparam logic [3:0] MAX_FAIL_C = 4'(MAX_FAIL);

    logic       rst_n;
    logic       key_meta_q;
    logic       key_sync_q;
    logic       key_prev_q;
    logic       enter_pulse;
    state_t     state_q, state_d;
    logic [3:0] fail_cnt_q, fail_cnt_d;

    // Active-low 7-segment decoder, bit0 = seg a ... bit6 = seg g.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign rst_n = KEY[1];

    // Two-flop synchroniser for ENTER plus a delayed copy for edge detection.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            key_prev_q <= 1'b1;
        end else begin
            key_meta_q <= KEY[0];
            key_sync_q <= key_meta_q;
            key_prev_q <= key_sync_q;
        end
    end

    // One pulse per press: synchronised key has just gone from released to pressed.
    assign enter_pulse = key_prev_q & ~key_sync_q;

    // Lock state and failure counter registers.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_LOCKED;
            fail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    // Next-state logic: act only on an enter pulse, comparing SW that same cycle.
    always_comb begin
        logic fail;
        state_d    = state_q;
        fail_cnt_d = fail_cnt_q;
        fail       = 1'b0;
        if (enter_pulse) begin
            case (state_q)
                S_LOCKED: begin
                    if (SW == CODE0) state_d = S_GOT1;
                    else             fail    = 1'b1;
                end
                S_GOT1: begin
                    if (SW == CODE1) state_d = S_GOT2;
                    else             fail    = 1'b1;
                end
                S_GOT2: begin
                    if (SW == CODE2) begin
                        state_d    = S_OPEN;
                        fail_cnt_d = '0;
                    end else begin
                        fail = 1'b1;
                    end
                end
                S_OPEN: begin
                    state_d    = S_LOCKED;
                    fail_cnt_d = '0;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
        if (fail) begin
            if (fail_cnt_q + 4'd1 == MAX_FAIL_C) begin
                state_d    = S_ALARM;
                fail_cnt_d = MAX_FAIL_C;
            end else begin
                state_d    = S_LOCKED;
                fail_cnt_d = fail_cnt_q + 4'd1;
            end
        end
    end

    // Display and LED outputs.
    always_comb begin
        HEX3 = seg7({1'b0, SW[6:4]});
        HEX2 = seg7(SW[3:0]);
        HEX1 = seg7(state_q);
        HEX0 = seg7(fail_cnt_q);
        LED  = SW;
    end

endmodule

// File: tb/tb_project3b_top.sv
// tb_project3b_top: directed vectors for the combination lock top.
module tb_project3b_top;

    logic       clk;
    logic [1:0] key;
    logic [6:0] sw;
    logic [6:0] hex3, hex2, hex1, hex0, led;

    int unsigned n_cmp;
    int unsigned n_bad;

    project3b_top #(
        .CODE0   (7'h12),
        .CODE1   (7'h34),
        .CODE2   (7'h56),
        .MAX_FAIL(3)
    ) dut (
        .CLOCK_50(clk),
        .KEY     (key),
        .SW      (sw),
        .HEX3    (hex3),
        .HEX2    (hex2),
        .HEX1    (hex1),
        .HEX0    (hex0),
        .LED     (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Press ENTER at a falling clock edge, hold briefly, release and settle.
    task automatic press(input logic [6:0] code);
        @(negedge clk);
        sw     = code;
        key[0] = 1'b0;
        repeat (4) @(negedge clk);
        key[0] = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Expected active-low segment patterns for digits 0..F.
    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    initial begin
        n_cmp = 0;
        n_bad = 0;
        key   = 2'b01;
        sw    = 7'h00;
        repeat (3) @(negedge clk);

        chk("rst_hex1", hex1, 7'h40);
        chk("rst_hex0", hex0, 7'h40);
        chk("rst_hex3", hex3, 7'h40);
        chk("rst_hex2", hex2, 7'h40);
        chk("rst_led",  led,  7'h00);

        key = 2'b11;
        repeat (3) @(negedge clk);

        // First press with latency check: state must move on the third rising edge.
        sw     = 7'h12;
        key[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("lat_2clk", hex1, 7'h40);
        @(negedge clk);
        chk("lat_3clk", hex1, 7'h79);
        repeat (2) @(negedge clk);
        key[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("got1_hold", hex1, 7'h79);

        press(7'h34);
        chk("got2", hex1, 7'h24);
        press(7'h56);
        chk("open", hex1, 7'h30);
        chk("open_cnt", hex0, 7'h40);

        press(7'h00);
        chk("relock", hex1, 7'h40);
        chk("relock_cnt", hex0, 7'h40);

        // Wrong code in GOT1.
        press(7'h12);
        chk("got1_b", hex1, 7'h79);
        press(7'h00);
        chk("wrong_state", hex1, 7'h40);
        chk("wrong_cnt", hex0, 7'h79);

        // Long hold must count exactly one failure.
        @(negedge clk);
        sw     = 7'h00;
        key[0] = 1'b0;
        repeat (100) @(negedge clk);
        chk("hold_cnt", hex0, 7'h24);
        key[0] = 1'b1;
        repeat (5) @(negedge clk);
        chk("release_cnt", hex0, 7'h24);
        chk("release_state", hex1, 7'h40);

        // Third failure trips the alarm.
        press(7'h11);
        chk("alarm_state", hex1, 7'h06);
        chk("alarm_cnt", hex0, 7'h30);

        press(7'h12);
        press(7'h34);
        press(7'h56);
        chk("alarm_sticky", hex1, 7'h06);
        chk("alarm_cnt_sticky", hex0, 7'h30);

        // Asynchronous reset: takes effect with no clock edge in between.
        @(posedge clk);
        #2;
        key[1] = 1'b0;
        #1;
        chk("async_rst_hex1", hex1, 7'h40);
        chk("async_rst_hex0", hex0, 7'h40);
        @(negedge clk);
        key[1] = 1'b1;
        repeat (3) @(negedge clk);

        // A successful open clears an earlier failure count (GOT2 path).
        press(7'h12);
        press(7'h34);
        press(7'h77);
        chk("got2_wrong_state", hex1, 7'h40);
        chk("got2_wrong_cnt", hex0, 7'h79);
        press(7'h12);
        press(7'h34);
        press(7'h56);
        chk("open2", hex1, 7'h30);
        chk("open2_cnt", hex0, 7'h40);

        // Combinational display path, sampled mid-cycle without waiting for an edge.
        @(posedge clk);
        #2;
        sw = 7'h5A;
        #1;
        chk("disp_led",  led,  7'h5A);
        chk("disp_hex3", hex3, 7'h12);
        chk("disp_hex2", hex2, 7'h08);

        for (int i = 0; i < 16; i++) begin
            sw = 7'(i);
            #1;
            chk($sformatf("seg_%0h", i), hex2, seg_tbl[i]);
        end
        for (int i = 0; i < 8; i++) begin
            sw = 7'(i << 4);
            #1;
            chk($sformatf("hex3_%0h", i), hex3, seg_tbl[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
